// File: rtl/wb_arb_pkg.sv
// Shared types for the writeback port arbiter: the buffered write request and grant encoding.
package wb_arb_pkg;

  localparam int WB_XLEN = 64;

  typedef struct packed {
    logic [4:0]         rd;
    logic [WB_XLEN-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_PIPE = 2'd1,
    GNT_LU   = 2'd2
  } grant_e;

  function automatic logic [31:0] rd_onehot(input logic [4:0] rd);
    return 32'd1 << rd;
  endfunction

endpackage

// File: rtl/wb_arb_fifo.sv
// Synchronous FIFO of writeback requests; exposes per-entry valid and rd so the
// top can build the busy mask from registered state only.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  wb_req_t                    push_data_i,
  input  logic                       pop_i,
  output wb_req_t                    head_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic [DEPTH-1:0]           ent_valid_o,
  output logic [DEPTH-1:0][4:0]      ent_rd_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wb_req_t          mem_q [DEPTH];
  logic [DEPTH-1:0] vld_q;
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  logic push_ok;
  logic pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  // A push into a full FIFO is only legal when the head leaves on the same edge.
  assign push_ok = push_i && (!full_o || pop_ok);

  assign head_o      = mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign ent_valid_o = vld_q;

  always_comb begin
    ent_rd_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_rd_o[i] = mem_q[i].rd;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (pop_ok) begin
        vld_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q        <= rd_ptr_q + PW'(1);
      end
      if (push_ok) begin
        vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between the WB stage and buffered long-latency results.
// Optional starvation guard enabled by defining WB_ARB_STARVE_GUARD_EN.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int XLEN         = WB_XLEN,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pipe_valid,
  input  logic                          pipe_en_rd,
  input  logic [4:0]                    pipe_rd,
  input  logic [XLEN-1:0]               pipe_data,
  output logic                          pipe_stall,
  input  logic                          lu_valid,
  output logic                          lu_ready,
  input  logic [4:0]                    lu_rd,
  input  logic [XLEN-1:0]               lu_data,
  output logic                          rf_we,
  output logic [4:0]                    rf_waddr,
  output logic [XLEN-1:0]               rf_wdata,
  output logic [31:0]                   busy_mask,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  wb_req_t                     head;
  wb_req_t                     push_req;
  logic                        fifo_full;
  logic                        fifo_empty;
  logic [CW-1:0]               fifo_cnt;
  logic [FIFO_DEPTH-1:0]       ent_valid;
  logic [FIFO_DEPTH-1:0][4:0]  ent_rd;

  logic   pipe_req;
  logic   lu_head;
  logic   lu_push;
  logic   lu_pop;
  logic   force_lu;
  grant_e gnt;
  logic [31:0] mask;

  assign pipe_req = pipe_valid && pipe_en_rd && (pipe_rd != 5'd0);
  assign lu_head  = !fifo_empty;
  assign lu_ready = !reset && !fifo_full;
  // Results for x0 complete the handshake but are never buffered.
  assign lu_push  = lu_valid && lu_ready && (lu_rd != 5'd0);
  assign push_req = '{rd: lu_rd, data: lu_data};

  wb_arb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (lu_push),
    .push_data_i (push_req),
    .pop_i       (lu_pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_cnt),
    .ent_valid_o (ent_valid),
    .ent_rd_o    (ent_rd)
  );

`ifdef WB_ARB_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_d;

  assign force_lu = lu_head && (starve_q == SW'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if ((gnt == GNT_LU) || !lu_head) begin
      starve_d = '0;
    end else if (pipe_req) begin
      starve_d = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

  assign pipe_stall = !reset && force_lu && pipe_req;
`else
  assign force_lu   = 1'b0;
  assign pipe_stall = 1'b0;
`endif

  always_comb begin
    gnt = GNT_NONE;
    if (reset) begin
      gnt = GNT_NONE;
    end else if (force_lu) begin
      gnt = GNT_LU;
    end else if (pipe_req) begin
      gnt = GNT_PIPE;
    end else if (lu_head) begin
      gnt = GNT_LU;
    end
  end

  assign lu_pop = (gnt == GNT_LU);

  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = '0;
    case (gnt)
      GNT_PIPE: begin
        rf_we    = 1'b1;
        rf_waddr = pipe_rd;
        rf_wdata = pipe_data;
      end
      GNT_LU: begin
        rf_we    = 1'b1;
        rf_waddr = head.rd;
        rf_wdata = head.data;
      end
      default: ;
    endcase
  end

  always_comb begin
    mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_valid[i]) begin
        mask = mask | rd_onehot(ent_rd[i]);
      end
    end
  end

  assign busy_mask  = reset ? 32'd0 : mask;
  assign fifo_count = reset ? '0 : fifo_cnt;

`ifndef SYNTHESIS
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_param_check
    $error("wb_port_arbiter: bad FIFO_DEPTH or STARVE_LIMIT");
  end

  // Decode must never let a WB write race a buffered write to the same register.
  a_no_busy_pipe_write: assert property (@(posedge clk) disable iff (reset)
    !(pipe_req && busy_mask[pipe_rd]))
    else $error("wb_port_arbiter: WB write to busy rd %0d", pipe_rd);
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter; define WB_ARB_STARVE_GUARD_EN to cover the starve guard.
module tb_wb_port_arbiter;

  localparam int XLEN = 64;
  localparam int W    = 5 + XLEN;

  logic            clk = 1'b0;
  logic            reset;
  logic            pipe_valid, pipe_en_rd;
  logic [4:0]      pipe_rd;
  logic [XLEN-1:0] pipe_data;
  logic            pipe_stall;
  logic            lu_valid, lu_ready;
  logic [4:0]      lu_rd;
  logic [XLEN-1:0] lu_data;
  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic [31:0]     busy_mask;
  logic [2:0]      fifo_count;

  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  wb_port_arbiter #(.XLEN(XLEN), .FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .pipe_valid (pipe_valid),
    .pipe_en_rd (pipe_en_rd),
    .pipe_rd    (pipe_rd),
    .pipe_data  (pipe_data),
    .pipe_stall (pipe_stall),
    .lu_valid   (lu_valid),
    .lu_ready   (lu_ready),
    .lu_rd      (lu_rd),
    .lu_data    (lu_data),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .busy_mask  (busy_mask),
    .fifo_count (fifo_count)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, required finish");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every regfile write is matched against the next expected write
  always @(negedge clk) begin
    logic [W-1:0] got;
    logic [W-1:0] exp_w;
    if (!reset && rf_we) begin
      checks++;
      got = {rf_waddr, rf_wdata};
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL wr_extra: got rd=%0d data=%h, required no write", rf_waddr, rf_wdata);
      end else begin
        exp_w = exp_q.pop_front();
        if (got !== exp_w) begin
          failures++;
          $display("FAIL wr_order: got rd=%0d data=%h, required rd=%0d data=%h",
                   rf_waddr, rf_wdata, exp_w[W-1 -: 5], exp_w[XLEN-1:0]);
        end
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_valid = 1'b0; pipe_en_rd = 1'b0; pipe_rd = 5'd0; pipe_data = '0;
    lu_valid   = 1'b0; lu_rd      = 5'd0; lu_data = '0;
  endtask

  task automatic drive_pipe(input logic [4:0] rd, input logic [XLEN-1:0] d);
    pipe_valid = 1'b1; pipe_en_rd = 1'b1; pipe_rd = rd; pipe_data = d;
  endtask

  task automatic drive_lu(input logic [4:0] rd, input logic [XLEN-1:0] d);
    lu_valid = 1'b1; lu_rd = rd; lu_data = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_pipe(5'd4, 64'h44);
    drive_lu(5'd6, 64'h66);
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b0 || lu_ready !== 1'b0 || pipe_stall !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctl: we=%b ready=%b stall=%b, required 0 0 0", rf_we, lu_ready, pipe_stall);
    end
    checks++;
    if (busy_mask !== 32'd0 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL reset_state: busy=%h count=%0d, required 0 0", busy_mask, fifo_count);
    end
    tick();
    idle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (lu_ready !== 1'b1 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL reset_release: ready=%b count=%0d, required 1 0", lu_ready, fifo_count);
    end
    tick();
  endtask

  task automatic test_lu_basic();
    drive_lu(5'd5, 64'hAA);
    exp_q.push_back({5'd5, 64'hAA});
    @(negedge clk);
    checks++;
    if (lu_ready !== 1'b1 || rf_we !== 1'b0 || busy_mask !== 32'd0) begin
      failures++;
      $display("FAIL lu_accept: ready=%b we=%b busy=%h, required 1 0 0", lu_ready, rf_we, busy_mask);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || busy_mask !== 32'h20 || fifo_count !== 3'd1) begin
      failures++;
      $display("FAIL lu_drain: we=%b busy=%h count=%0d, required 1 00000020 1", rf_we, busy_mask, fifo_count);
    end
    tick();
    @(negedge clk);
    checks++;
    if (busy_mask !== 32'd0 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL lu_clear: busy=%h count=%0d, required 0 0", busy_mask, fifo_count);
    end
    tick();
  endtask

  task automatic test_priority();
    drive_pipe(5'd3, 64'h33);
    drive_lu(5'd7, 64'h77);
    exp_q.push_back({5'd3, 64'h33});
    @(negedge clk);
    checks++;
    if (rf_waddr !== 5'd3) begin
      failures++;
      $display("FAIL prio_first: waddr=%0d, required 3", rf_waddr);
    end
    tick();
    lu_valid = 1'b0;
    drive_pipe(5'd3, 64'h34);
    exp_q.push_back({5'd3, 64'h34});
    @(negedge clk);
    checks++;
    if (rf_waddr !== 5'd3 || busy_mask !== 32'h80 || fifo_count !== 3'd1) begin
      failures++;
      $display("FAIL prio_pipe_wins: waddr=%0d busy=%h count=%0d, required 3 00000080 1",
               rf_waddr, busy_mask, fifo_count);
    end
    tick();
    idle();
    exp_q.push_back({5'd7, 64'h77});
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7) begin
      failures++;
      $display("FAIL prio_idle_slot: we=%b waddr=%0d, required 1 7", rf_we, rf_waddr);
    end
    tick();
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL prio_empty: count=%0d, required 0", fifo_count);
    end
    tick();
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      drive_pipe(5'd1, 64'h100 + 64'(k));
      drive_lu(5'(20 + k), 64'h200 + 64'(k));
      exp_q.push_back({5'd1, 64'h100 + 64'(k)});
      @(negedge clk);
      checks++;
      if (lu_ready !== 1'b1 || fifo_count !== 3'(k)) begin
        failures++;
        $display("FAIL fill_%0d: ready=%b count=%0d, required 1 %0d", k, lu_ready, fifo_count, k);
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      drive_pipe(5'd1, 64'h104 + 64'(k));
      drive_lu(5'd24, 64'h224);
      exp_q.push_back({5'd1, 64'h104 + 64'(k)});
      @(negedge clk);
      checks++;
      if (lu_ready !== 1'b0 || fifo_count !== 3'd4 || busy_mask !== 32'h00F0_0000) begin
        failures++;
        $display("FAIL full_hold_%0d: ready=%b count=%0d busy=%h, required 0 4 00f00000",
                 k, lu_ready, fifo_count, busy_mask);
      end
      tick();
    end
    for (int k = 0; k < 4; k++) begin
      idle();
      exp_q.push_back({5'(20 + k), 64'h200 + 64'(k)});
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b1 || fifo_count !== 3'(4 - k)) begin
        failures++;
        $display("FAIL drain_%0d: we=%b count=%0d, required 1 %0d", k, rf_we, fifo_count, 4 - k);
      end
      tick();
    end
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd0 || busy_mask !== 32'd0) begin
      failures++;
      $display("FAIL drain_done: count=%0d busy=%h, required 0 0", fifo_count, busy_mask);
    end
    tick();
  endtask

  task automatic test_zero();
    drive_lu(5'd0, 64'hDEAD);
    drive_pipe(5'd0, 64'hBEEF);
    @(negedge clk);
    checks++;
    if (lu_ready !== 1'b1 || rf_we !== 1'b0) begin
      failures++;
      $display("FAIL x0_slot: ready=%b we=%b, required 1 0", lu_ready, rf_we);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd0 || rf_we !== 1'b0 || busy_mask !== 32'd0) begin
      failures++;
      $display("FAIL x0_drop: count=%0d we=%b busy=%h, required 0 0 0", fifo_count, rf_we, busy_mask);
    end
    tick();
    drive_lu(5'd9, 64'h99);
    exp_q.push_back({5'd9, 64'h99});
    @(negedge clk);
    tick();
    idle();
    pipe_valid = 1'b1; pipe_en_rd = 1'b0; pipe_rd = 5'd9; pipe_data = 64'h1;
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd9) begin
      failures++;
      $display("FAIL no_en_rd_slot: we=%b waddr=%0d, required 1 9", rf_we, rf_waddr);
    end
    tick();
    idle();
    tick();
  endtask

`ifdef WB_ARB_STARVE_GUARD_EN
  task automatic test_starve();
    drive_pipe(5'd1, 64'h500);
    drive_lu(5'd15, 64'hF15);
    exp_q.push_back({5'd1, 64'h500});
    @(negedge clk);
    tick();
    lu_valid = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      drive_pipe(5'd1, 64'h500 + 64'(c));
      exp_q.push_back({5'd1, 64'h500 + 64'(c)});
      @(negedge clk);
      checks++;
      if (pipe_stall !== 1'b0 || rf_waddr !== 5'd1) begin
        failures++;
        $display("FAIL starve_lose_%0d: stall=%b waddr=%0d, required 0 1", c, pipe_stall, rf_waddr);
      end
      tick();
    end
    drive_pipe(5'd1, 64'h509);
    exp_q.push_back({5'd15, 64'hF15});
    @(negedge clk);
    checks++;
    if (pipe_stall !== 1'b1 || rf_waddr !== 5'd15) begin
      failures++;
      $display("FAIL starve_force: stall=%b waddr=%0d, required 1 15", pipe_stall, rf_waddr);
    end
    tick();
    exp_q.push_back({5'd1, 64'h509});
    @(negedge clk);
    checks++;
    if (pipe_stall !== 1'b0 || rf_waddr !== 5'd1 || fifo_count !== 3'd0) begin
      failures++;
      $display("FAIL starve_retry: stall=%b waddr=%0d count=%0d, required 0 1 0",
               pipe_stall, rf_waddr, fifo_count);
    end
    tick();
    idle();
    tick();
  endtask
`else
  task automatic test_starve();
    drive_pipe(5'd1, 64'h500);
    drive_lu(5'd15, 64'hF15);
    exp_q.push_back({5'd1, 64'h500});
    @(negedge clk);
    tick();
    lu_valid = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      drive_pipe(5'd1, 64'h500 + 64'(c));
      exp_q.push_back({5'd1, 64'h500 + 64'(c)});
      @(negedge clk);
      checks++;
      if (pipe_stall !== 1'b0 || rf_waddr !== 5'd1 || fifo_count !== 3'd1) begin
        failures++;
        $display("FAIL no_guard_%0d: stall=%b waddr=%0d count=%0d, required 0 1 1",
                 c, pipe_stall, rf_waddr, fifo_count);
      end
      tick();
    end
    idle();
    exp_q.push_back({5'd15, 64'hF15});
    @(negedge clk);
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd15) begin
      failures++;
      $display("FAIL no_guard_drain: we=%b waddr=%0d, required 1 15", rf_we, rf_waddr);
    end
    tick();
  endtask
`endif

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) begin
      drive_pipe(5'd2, 64'h600 + 64'(k));
      drive_lu(5'(25 + k), 64'h700 + 64'(k));
      exp_q.push_back({5'd2, 64'h600 + 64'(k)});
      @(negedge clk);
      tick();
    end
    idle();
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd3 || busy_mask !== 32'h0E00_0000) begin
      failures++;
      $display("FAIL pre_reset: count=%0d busy=%h, required 3 0e000000", fifo_count, busy_mask);
    end
    // Reset lands before the idle slot can drain anything.
    reset = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd0 || busy_mask !== 32'd0 || rf_we !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: count=%0d busy=%h we=%b, required 0 0 0", fifo_count, busy_mask, rf_we);
    end
    tick();
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (rf_we !== 1'b0 || fifo_count !== 3'd0) begin
        failures++;
        $display("FAIL post_reset_%0d: we=%b count=%0d, required 0 0", c, rf_we, fifo_count);
      end
      tick();
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    tick();
    test_reset();
    test_lu_basic();
    test_priority();
    test_full();
    test_zero();
    test_starve();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: %0d writes outstanding, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
